// File: rtl/operand_fetch.sv
// Operand fetch stage: drives register-file reads, bypasses same-cycle writeback,
// tracks pending writes per register and stalls on RAW/WAW hazards.
module operand_fetch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wr_en,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr_en,
  output logic [NREGS-1:0]  pending
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic [DATA_W-1:0] op_a_d, op_b_d;
  logic [ADDR_W-1:0] out_rd_q;
  logic              out_wr_en_q;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [NREGS-1:0]  wb_clr;
  logic              eff_wr, raw1, raw2, waw, fire;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  always_comb begin
    wb_clr = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (wb_en && (wb_rd == ADDR_W'(r))) wb_clr[r] = 1'b1;
    end
  end

  // A writeback landing this cycle resolves the hazard, since its value is bypassed.
  assign eff_wr   = in_wr_en && (in_rd != '0);
  assign raw1     = (in_rs1 != '0) && pending_q[in_rs1] && !wb_clr[in_rs1];
  assign raw2     = (in_rs2 != '0) && pending_q[in_rs2] && !wb_clr[in_rs2];
  assign waw      = eff_wr && pending_q[in_rd] && !wb_clr[in_rd];
  assign in_ready = (!out_valid_q || out_ready) && !raw1 && !raw2 && !waw && !flush;
  assign fire     = in_valid && in_ready;

  always_comb begin
    op_a_d = rf_rs1_data;
    op_b_d = rf_rs2_data;
    if (in_rs1 == '0)                      op_a_d = '0;
    else if (wb_en && (wb_rd == in_rs1))   op_a_d = wb_data;
    if (in_rs2 == '0)                      op_b_d = '0;
    else if (wb_en && (wb_rd == in_rs2))   op_b_d = wb_data;
  end

  // Ordering gives set priority over both writeback clear and flush clear.
  always_comb begin
    pending_d = pending_q & ~wb_clr;
    if (flush && out_valid_q && out_wr_en_q) pending_d[out_rd_q] = 1'b0;
    if (fire && eff_wr)                      pending_d[in_rd]    = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_wr_en_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (fire) begin
        out_valid_q <= 1'b1;
        out_a_q     <= op_a_d;
        out_b_q     <= op_b_d;
        out_rd_q    <= in_rd;
        out_wr_en_q <= eff_wr;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_rd    = out_rd_q;
  assign out_wr_en = out_wr_en_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; issued instructions are queued and compared
// against the output register when it presents them.
module tb_operand_fetch;

  logic        clk, rst;
  logic        in_valid, in_ready, in_wr_en;
  logic [3:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, wb_rd, out_rd;
  logic [15:0] rf_rs1_data, rf_rs2_data, wb_data, out_a, out_b;
  logic        wb_en, flush, out_valid, out_ready, out_wr_en;
  logic [15:0] pending;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
    logic        wr;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  ov = 1'b0;

  operand_fetch #(.DATA_W(16), .ADDR_W(4), .NREGS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic wr,
                       input logic [15:0] d1, input logic [15:0] d2,
                       input logic wbe, input logic [3:0] wbrd, input logic [15:0] wbd);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wr_en = wr;
    rf_rs1_data = d1; rf_rs2_data = d2;
    wb_en = wbe; wb_rd = wbrd; wb_data = wbd;
  endtask

  function automatic logic [15:0] opnd(input logic [3:0] s, input logic [15:0] rf);
    if (s == 4'd0) return 16'h0;
    if (wb_en && wb_rd == s) return wb_data;
    return rf;
  endfunction

  // One clock: check in_ready before the edge, then registered state after it.
  task automatic step(input logic exp_rdy, input logic exp_val, input logic [15:0] exp_pend);
    item_t it;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("rf_rs1", {28'b0, rf_rs1}, {28'b0, in_rs1});
    if (ov && (out_ready || flush) && exp_q.size() > 0) it = exp_q.pop_front();
    if (in_valid && exp_rdy) begin
      it.a  = opnd(in_rs1, rf_rs1_data);
      it.b  = opnd(in_rs2, rf_rs2_data);
      it.rd = in_rd;
      it.wr = in_wr_en && (in_rd != 4'd0);
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_val});
    chk("pending", {16'b0, pending}, {16'b0, exp_pend});
    if (exp_val) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL queue: got empty expected an entry");
      end
      if (exp_q.size() > 0) begin
        chk("out_a", {16'b0, out_a}, {16'b0, exp_q[0].a});
        chk("out_b", {16'b0, out_b}, {16'b0, exp_q[0].b});
        chk("out_rd", {28'b0, out_rd}, {28'b0, exp_q[0].rd});
        chk("out_wr_en", {31'b0, out_wr_en}, {31'b0, exp_q[0].wr});
      end
    end
    ov = exp_val;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_a", {16'b0, out_a}, 32'h0);
    chk("rst_out_b", {16'b0, out_b}, 32'h0);
    chk("rst_out_rd", {28'b0, out_rd}, 32'h0);
    chk("rst_out_wr_en", {31'b0, out_wr_en}, 32'h0);
    chk("rst_pending", {16'b0, pending}, 32'h0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Basic issue
    drive(1, 3, 4, 5, 1, 16'h1111, 16'h2222, 0, 0, 16'h0);
    step(1, 1, 16'h0020);
    // RAW stall on r5, then resolved by same-cycle writeback with bypass
    drive(1, 5, 0, 0, 0, 16'hAAAA, 16'h0, 0, 0, 16'h0);
    step(0, 0, 16'h0020);
    drive(1, 5, 0, 0, 0, 16'hAAAA, 16'h0, 1, 5, 16'hBEEF);
    step(1, 1, 16'h0000);
    // WAW on r7; release writeback coincides with the new set
    drive(1, 1, 2, 7, 1, 16'h0101, 16'h0202, 0, 0, 16'h0);
    step(1, 1, 16'h0080);
    drive(1, 2, 1, 7, 1, 16'h0202, 16'h0101, 0, 0, 16'h0);
    step(0, 0, 16'h0080);
    drive(1, 2, 1, 7, 1, 16'h0202, 16'h0101, 1, 7, 16'h7777);
    step(1, 1, 16'h0080);
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 1, 7, 16'h7777);
    step(1, 0, 16'h0000);
    // Register 0 sources and destination
    drive(1, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0, 16'h0);
    step(1, 1, 16'h0000);
    // Backpressure for three cycles, then accept
    out_ready = 1'b0;
    drive(1, 3, 4, 9, 1, 16'h1234, 16'h5678, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0000);
    out_ready = 1'b1;
    step(1, 1, 16'h0200);
    // Flush clears the held instruction and its pending bit
    out_ready = 1'b0; flush = 1'b1;
    drive(1, 1, 0, 2, 1, 16'h4444, 16'h0, 0, 0, 16'h0);
    step(0, 0, 16'h0000);
    flush = 1'b0; out_ready = 1'b1;
    // Asynchronous reset while stalled
    drive(1, 0, 0, 6, 1, 16'h0, 16'h0, 0, 0, 16'h0);
    step(1, 1, 16'h0040);
    out_ready = 1'b0;
    drive(1, 6, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_out_a", {16'b0, out_a}, 32'h0);
    chk("arst_out_rd", {28'b0, out_rd}, 32'h0);
    chk("arst_out_wr_en", {31'b0, out_wr_en}, 32'h0);
    chk("arst_pending", {16'b0, pending}, 32'h0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'h1);
    exp_q.delete();
    ov = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    // Stale writeback after reset leaves the scoreboard empty
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 1, 6, 16'h6666);
    step(1, 0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side companion of the 16x16 register file: accepts decoded instructions, drives register-file read addresses, and captures operands into a one-entry pipeline register for the execute stage.
- Bypasses the same-cycle writeback value, because register-file writes land only at the next clock edge.
- Keeps a per-register pending-write scoreboard and stalls issue on RAW and WAW hazards against in-flight writes.
- Sits between decode and execute; snoops the writeback port that feeds the register file.

Parameters:
- DATA_W, 16, operand/data width
- ADDR_W, 4, register address width
- NREGS, 16, number of architectural registers (2**ADDR_W); register 0 hardwired to zero

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  fetch stage can accept instruction this cycle
- in_rs1  in  ADDR_W  source register 1
- in_rs2  in  ADDR_W  source register 2
- in_rd  in  ADDR_W  destination register
- in_wr_en  in  1  instruction writes in_rd
- rf_rs1  out  ADDR_W  register-file read address 1 (= in_rs1, combinational)
- rf_rs2  out  ADDR_W  register-file read address 2 (= in_rs2, combinational)
- rf_rs1_data  in  DATA_W  register-file read data 1 (combinational read)
- rf_rs2_data  in  DATA_W  register-file read data 2
- wb_en  in  1  writeback this cycle (same signal driving the register-file write enable)
- wb_rd  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- flush  in  1  discard the instruction held in the output register
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_a  out  DATA_W  operand 1
- out_b  out  DATA_W  operand 2
- out_rd  out  ADDR_W  destination
- out_wr_en  out  1  destination write enable
- pending  out  NREGS  scoreboard vector (bit i = write to register i outstanding)

Behaviour:
- Reset (async): out_valid=0, out_a=0, out_b=0, out_rd=0, out_wr_en=0, pending=0. in_ready follows combinationally from the reset state, so it is 1 while rst is high.
- Effective write: eff_wr = in_wr_en && in_rd!=0. Writes to register 0 are never tracked.
- Clear condition: wb_clear(r) = wb_en && wb_rd==r && r!=0.
- Hazards:
  - raw1 = in_rs1!=0 && pending[in_rs1] && !wb_clear(in_rs1); raw2 likewise for in_rs2.
  - waw = eff_wr && pending[in_rd] && !wb_clear(in_rd).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !raw1 && !raw2 && !waw; fire = in_valid && in_ready.
  - Output handshake is valid/ready. out_* stay stable while out_valid && !out_ready.
- Operand select, per source s:
  - s==0: 0.
  - Otherwise, if wb_en && wb_rd==s: wb_data (bypass).
  - Otherwise: rf data.
- Latency: one cycle from fire to out_valid=1 with captured operands. Back-to-back issue is allowed when out_ready=1.
- Output register, per cycle:
  - fire: load operands, out_rd, out_wr_en=eff_wr; out_valid=1.
  - Otherwise, if out_ready: out_valid=0. Data holds.
  - flush: out_valid=0 next cycle and fire is suppressed (in_ready forced 0 while flush=1).
- Scoreboard, per cycle and per bit:
  - Set: fire && eff_wr at in_rd.
  - Clear: wb_clear.
  - Same bit set and cleared in one cycle: set wins.
  - Flush while out_valid && out_wr_en: clear pending[out_rd], unless wb_clear or a set on the same bit also occurs (set wins).
  - Clear on a bit not set: no effect. Bit 0 stays 0 always.
- Ordering assumption: at most one write outstanding per register (guaranteed by the WAW stall). Writebacks arrive in any order across different registers.
- Reset mid-operation: everything returns to reset state immediately. Any in-flight writeback after reset is ignored because its pending bit is already 0.

Test Plan:
- Reset, then issue rs1=3, rs2=4, rd=5, wr_en=1 with rf returning 0x1111/0x2222 -> next cycle out_valid=1, out_a=0x1111, out_b=0x2222, out_rd=5, pending=0x0020.
- pending[5]=1, issue rs1=5 with no writeback -> in_ready=0, stall holds. Then wb_en=1, wb_rd=5, wb_data=0xBEEF in the same cycle -> fire, out_a=0xBEEF (bypass), pending[5] cleared.
- Issue rd=7, then rd=7 again before writeback -> second stalls (WAW) until wb_rd=7. Same-cycle set of bit 7 plus wb clear of bit 7 -> pending[7]=1.
- rs1=0, rs2=0, rd=0, wr_en=1 with rf driving 0xFFFF -> out_a=0, out_b=0, out_wr_en=0, pending unchanged.
- out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out_* stable. Then out_ready=1 -> next instruction accepted same cycle.
- out_valid=1 with out_rd=9, out_wr_en=1, assert flush -> out_valid=0 and pending[9]=0 next cycle. Also assert rst mid-stall -> all outputs and pending=0 asynchronously.
